// File: rtl/float_result_lcd_writer.sv
// Captures a 32-bit adder result and writes it to a 16x2 character LCD as 32 binary digits.
// Define LCD_PENDING_BUF_EN to queue one result that arrives mid-refresh instead of dropping it.
module float_result_lcd_writer #(
   parameter int INIT_WAIT_CYCLES = 750000,
   parameter int EN_PULSE_CYCLES  = 25,
   parameter int SETTLE_CYCLES    = 2500,
   parameter int CLEAR_CYCLES     = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] result,
   input  logic        result_valid,
   output logic        busy,
   output logic        done,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_enable
);

   localparam logic [2:0] ST_WAIT_PWR = 3'd0;
   localparam logic [2:0] ST_INIT     = 3'd1;
   localparam logic [2:0] ST_IDLE     = 3'd2;
   localparam logic [2:0] ST_L1_ADDR  = 3'd3;
   localparam logic [2:0] ST_L1_CHARS = 3'd4;
   localparam logic [2:0] ST_L2_ADDR  = 3'd5;
   localparam logic [2:0] ST_L2_CHARS = 3'd6;
   localparam logic [2:0] ST_FINISH   = 3'd7;

   localparam logic [1:0] PH_SETUP = 2'd0;
   localparam logic [1:0] PH_PULSE = 2'd1;
   localparam logic [1:0] PH_HOLD  = 2'd2;

   localparam int MAX_A      = (INIT_WAIT_CYCLES > EN_PULSE_CYCLES) ? INIT_WAIT_CYCLES : EN_PULSE_CYCLES;
   localparam int MAX_B      = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
   localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [TIMER_W-1:0] WAIT_LAST   = TIMER_W'(INIT_WAIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(EN_PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] CLEAR_LAST  = TIMER_W'(CLEAR_CYCLES - 1);

   logic [2:0]         state_reg, state_next;
   logic [1:0]         phase_reg, phase_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic [1:0]         init_idx_reg, init_idx_next;
   logic [4:0]         bit_idx_reg, bit_idx_next;
   logic [31:0]        capture_reg, capture_next;
   logic [7:0]         lcd_data_reg;
   logic               lcd_rs_reg;
   logic               lcd_enable_reg;
   logic               settle_last;

`ifdef LCD_PENDING_BUF_EN
   logic               pend_valid_reg, pend_valid_next;
   logic [31:0]        pend_data_reg, pend_data_next;
`endif

   function automatic logic is_write_state(input logic [2:0] st);
      return st inside {ST_INIT, ST_L1_ADDR, ST_L1_CHARS, ST_L2_ADDR, ST_L2_CHARS};
   endfunction

   // {rs, data} presented on the bus for a given write state.
   function automatic logic [8:0] bus_word(input logic [2:0]  st,
                                           input logic [1:0]  ii,
                                           input logic [4:0]  bi,
                                           input logic [31:0] cap);
      logic [8:0] w;
      w = 9'h000;
      case (st)
         ST_INIT: begin
            case (ii)
               2'd0:    w = 9'h038;
               2'd1:    w = 9'h00C;
               2'd2:    w = 9'h006;
               default: w = 9'h001;
            endcase
         end
         ST_L1_ADDR:              w = 9'h080;
         ST_L2_ADDR:              w = 9'h0C0;
         ST_L1_CHARS, ST_L2_CHARS: w = {1'b1, 7'b0011000, cap[bi]};
         default:                 w = 9'h000;
      endcase
      return w;
   endfunction

   // The clear command needs a much longer settle than every other write.
   always_comb begin
      if (state_reg == ST_INIT && init_idx_reg == 2'd3) begin
         settle_last = (timer_reg == CLEAR_LAST);
      end else begin
         settle_last = (timer_reg == SETTLE_LAST);
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      timer_next    = timer_reg;
      init_idx_next = init_idx_reg;
      bit_idx_next  = bit_idx_reg;
      capture_next  = capture_reg;
`ifdef LCD_PENDING_BUF_EN
      pend_valid_next = pend_valid_reg;
      pend_data_next  = pend_data_reg;
`endif
      case (state_reg)
         ST_WAIT_PWR: begin
            if (timer_reg == WAIT_LAST) begin
               state_next    = ST_INIT;
               phase_next    = PH_SETUP;
               timer_next    = '0;
               init_idx_next = 2'd0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         ST_IDLE: begin
            if (result_valid) begin
               capture_next = result;
               state_next   = ST_L1_ADDR;
               phase_next   = PH_SETUP;
               timer_next   = '0;
               bit_idx_next = 5'd31;
            end
         end
         ST_FINISH: begin
`ifdef LCD_PENDING_BUF_EN
            if (pend_valid_reg) begin
               capture_next    = pend_data_reg;
               pend_valid_next = 1'b0;
               state_next      = ST_L1_ADDR;
               phase_next      = PH_SETUP;
               timer_next      = '0;
               bit_idx_next    = 5'd31;
            end else begin
               state_next = ST_IDLE;
            end
`else
            state_next = ST_IDLE;
`endif
         end
         default: begin
            case (phase_reg)
               PH_SETUP: begin
                  phase_next = PH_PULSE;
                  timer_next = '0;
               end
               PH_PULSE: begin
                  if (timer_reg == PULSE_LAST) begin
                     phase_next = PH_HOLD;
                     timer_next = '0;
                  end else begin
                     timer_next = timer_reg + 1'b1;
                  end
               end
               default: begin
                  if (settle_last) begin
                     phase_next = PH_SETUP;
                     timer_next = '0;
                     case (state_reg)
                        ST_INIT: begin
                           if (init_idx_reg == 2'd3) begin
                              state_next = ST_IDLE;
                           end else begin
                              init_idx_next = init_idx_reg + 2'd1;
                           end
                        end
                        ST_L1_ADDR: state_next = ST_L1_CHARS;
                        ST_L1_CHARS: begin
                           bit_idx_next = bit_idx_reg - 5'd1;
                           if (bit_idx_reg == 5'd16) begin
                              state_next = ST_L2_ADDR;
                           end
                        end
                        ST_L2_ADDR: state_next = ST_L2_CHARS;
                        default: begin
                           // Bit 0 is the last character; the index stops there.
                           if (bit_idx_reg == 5'd0) begin
                              state_next = ST_FINISH;
                           end else begin
                              bit_idx_next = bit_idx_reg - 5'd1;
                           end
                        end
                     endcase
                  end else begin
                     timer_next = timer_reg + 1'b1;
                  end
               end
            endcase
`ifdef LCD_PENDING_BUF_EN
            if (result_valid && state_reg != ST_INIT) begin
               pend_valid_next = 1'b1;
               pend_data_next  = result;
            end
`endif
         end
      endcase
   end

   // Bus outputs are registered from the next-state values so they change only on clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_WAIT_PWR;
         phase_reg      <= PH_SETUP;
         timer_reg      <= '0;
         init_idx_reg   <= 2'd0;
         bit_idx_reg    <= 5'd31;
         capture_reg    <= 32'd0;
         lcd_data_reg   <= 8'd0;
         lcd_rs_reg     <= 1'b0;
         lcd_enable_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         phase_reg      <= phase_next;
         timer_reg      <= timer_next;
         init_idx_reg   <= init_idx_next;
         bit_idx_reg    <= bit_idx_next;
         capture_reg    <= capture_next;
         {lcd_rs_reg, lcd_data_reg} <= bus_word(state_next, init_idx_next, bit_idx_next, capture_next);
         lcd_enable_reg <= is_write_state(state_next) && (phase_next == PH_PULSE);
      end
   end

`ifdef LCD_PENDING_BUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= 32'd0;
      end else begin
         pend_valid_reg <= pend_valid_next;
         pend_data_reg  <= pend_data_next;
      end
   end
`endif

   assign busy       = (state_reg != ST_IDLE);
   assign done       = (state_reg == ST_FINISH);
   assign lcd_data   = lcd_data_reg;
   assign lcd_rs     = lcd_rs_reg;
   assign lcd_enable = lcd_enable_reg;

endmodule

// File: tb/tb_float_result_lcd_writer.sv
// Bench for float_result_lcd_writer: bus-level checks of init, refresh content/timing, pending and reset.
module tb_float_result_lcd_writer;

   localparam int INIT_WAIT = 10;
   localparam int EN_PULSE  = 2;
   localparam int SETTLE    = 4;
   localparam int CLEAR     = 8;
   localparam int PERIOD    = 1 + EN_PULSE + SETTLE;
   localparam int TIMEOUT   = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] result = 32'd0;
   logic        result_valid = 1'b0;
   logic        busy, done, lcd_rs, lcd_enable;
   logic [7:0]  lcd_data;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   rise_cnt = 0;
   logic en_q = 1'b0;

   float_result_lcd_writer #(
      .INIT_WAIT_CYCLES (INIT_WAIT),
      .EN_PULSE_CYCLES  (EN_PULSE),
      .SETTLE_CYCLES    (SETTLE),
      .CLEAR_CYCLES     (CLEAR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done),
      .lcd_data     (lcd_data),
      .lcd_rs       (lcd_rs),
      .lcd_enable   (lcd_enable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      en_q <= lcd_enable;
      if (lcd_enable === 1'b1 && en_q !== 1'b1) rise_cnt <= rise_cnt + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Expected {rs,data} of write k (0..33) of a refresh showing v.
   function automatic logic [8:0] ref_word(input logic [31:0] v, input int k);
      int bitpos;
      if (k == 0)  return 9'h080;
      if (k == 17) return 9'h0C0;
      bitpos = (k < 17) ? (32 - k) : (33 - k);
      return {1'b1, 8'(32'h30 + ((v >> bitpos) & 32'd1))};
   endfunction

   // Waits for the next enable strobe and checks its cycle, word, width and held word.
   task automatic expect_write(input logic [8:0] exp_w, input int exp_rise, input string tag);
      int n;
      int hi;
      n = 0;
      while (lcd_enable !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " rise cycle"}, cyc, exp_rise);
      chk({tag, " word"}, {23'd0, lcd_rs, lcd_data}, {23'd0, exp_w});
      hi = 0;
      while (lcd_enable === 1'b1 && hi < TIMEOUT) begin
         @(negedge clk);
         hi++;
      end
      chk({tag, " enable width"}, hi, EN_PULSE);
      chk({tag, " hold word"}, {23'd0, lcd_rs, lcd_data}, {23'd0, exp_w});
   endtask

   task automatic check_init(input int rel);
      int r;
      wait_cyc(rel + 1);
      chk("wait_pwr data", {24'd0, lcd_data}, 32'd0);
      chk("wait_pwr enable", {31'd0, lcd_enable}, 32'd0);
      chk("wait_pwr busy", {31'd0, busy}, 32'd1);
      result = 32'hDEADBEEF;
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0;
      r = rel + INIT_WAIT + 1;
      expect_write(9'h038, r, "init 38");
      r += PERIOD;
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0;
      expect_write(9'h00C, r, "init 0C");
      r += PERIOD;
      expect_write(9'h006, r, "init 06");
      r += PERIOD;
      expect_write(9'h001, r, "init 01");
      wait_cyc(r + EN_PULSE + CLEAR - 1);
      chk("busy during clear settle", {31'd0, busy}, 32'd1);
      wait_cyc(r + EN_PULSE + CLEAR);
      chk("busy after init", {31'd0, busy}, 32'd0);
      chk("done after init", {31'd0, done}, 32'd0);
   endtask

   task automatic start_refresh(input logic [31:0] val, output int first_rise);
      @(negedge clk);
      chk("idle busy before capture", {31'd0, busy}, 32'd0);
      result = val;
      result_valid = 1'b1;
      first_rise = cyc + 2;
      @(negedge clk);
      result_valid = 1'b0;
      result = $urandom;
      chk("busy after capture", {31'd0, busy}, 32'd1);
   endtask

   task automatic run_refresh(input logic [31:0] val, input int first_rise, input int nwrites,
                              input int inj_k1, input logic [31:0] inj_v1,
                              input int inj_k2, input logic [31:0] inj_v2,
                              output int last_rise);
      int rise;
      rise = first_rise;
      last_rise = first_rise;
      for (int k = 0; k < nwrites; k++) begin
         expect_write(ref_word(val, k), rise, $sformatf("v%08h w%0d", val, k));
         last_rise = rise;
         rise += PERIOD;
         if (k == inj_k1 || k == inj_k2) begin
            result = (k == inj_k1) ? inj_v1 : inj_v2;
            result_valid = 1'b1;
            @(negedge clk);
            result_valid = 1'b0;
         end
         result = $urandom;
      end
   endtask

   task automatic check_done(input int last_rise, input logic exp_busy_after, input string tag);
      wait_cyc(last_rise + EN_PULSE + SETTLE - 1);
      chk({tag, " done before"}, {31'd0, done}, 32'd0);
      wait_cyc(last_rise + EN_PULSE + SETTLE);
      chk({tag, " done pulse"}, {31'd0, done}, 32'd1);
      chk({tag, " busy at done"}, {31'd0, busy}, 32'd1);
      wait_cyc(last_rise + EN_PULSE + SETTLE + 1);
      chk({tag, " done after"}, {31'd0, done}, 32'd0);
      chk({tag, " busy after"}, {31'd0, busy}, {31'd0, exp_busy_after});
   endtask

   initial begin
      int r;
      int r2;
      int r3;
      int rel;
      int rc0;
      int dc0;
      int n;
      logic [31:0] v;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset lcd_data", {24'd0, lcd_data}, 32'd0);
      chk("reset lcd_rs", {31'd0, lcd_rs}, 32'd0);
      chk("reset lcd_enable", {31'd0, lcd_enable}, 32'd0);
      chk("reset busy", {31'd0, busy}, 32'd1);
      chk("reset done", {31'd0, done}, 32'd0);
      rel = cyc;
      rst_n = 1'b1;
      check_init(rel);

      rc0 = rise_cnt;
      repeat (20) @(negedge clk);
      chk("idle no writes", rise_cnt, rc0);
      chk("idle busy", {31'd0, busy}, 32'd0);

      start_refresh(32'h3FC00000, r);
      run_refresh(32'h3FC00000, r, 34, -1, 32'd0, -1, 32'd0, r2);
      check_done(r2, 1'b0, "1.5");

      start_refresh(32'hFFFF0001, r);
      run_refresh(32'hFFFF0001, r, 34, -1, 32'd0, -1, 32'd0, r2);
      check_done(r2, 1'b0, "FFFF0001");

      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         start_refresh(v, r);
         run_refresh(v, r, 34, -1, 32'd0, -1, 32'd0, r2);
         check_done(r2, 1'b0, $sformatf("rand%0d", i));
      end

      repeat (4) @(negedge clk);
      dc0 = done_cnt;
      rc0 = rise_cnt;
      start_refresh(32'h40000000, r);
      run_refresh(32'h40000000, r, 34, 3, 32'hC0000000, 20, 32'h41200000, r2);
`ifdef LCD_PENDING_BUF_EN
      check_done(r2, 1'b1, "pend first");
      run_refresh(32'h41200000, r2 + EN_PULSE + SETTLE + 2, 34, -1, 32'd0, -1, 32'd0, r3);
      check_done(r3, 1'b0, "pend second");
      repeat (40) @(negedge clk);
      chk("pend done count", done_cnt - dc0, 2);
      chk("pend write count", rise_cnt - rc0, 68);
`else
      check_done(r2, 1'b0, "drop");
      repeat (40) @(negedge clk);
      chk("drop done count", done_cnt - dc0, 1);
      chk("drop write count", rise_cnt - rc0, 34);
      chk("drop busy", {31'd0, busy}, 32'd0);
`endif

      v = $urandom;
      start_refresh(v, r);
      run_refresh(v, r, 6, -1, 32'd0, -1, 32'd0, r2);
      n = 0;
      while (lcd_enable !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      chk("pre-reset enable", {31'd0, lcd_enable}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midwrite reset enable", {31'd0, lcd_enable}, 32'd0);
      chk("midwrite reset rs", {31'd0, lcd_rs}, 32'd0);
      chk("midwrite reset data", {24'd0, lcd_data}, 32'd0);
      chk("midwrite reset busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rel = cyc;
      rst_n = 1'b1;
      check_init(rel);

      v = $urandom;
      start_refresh(v, r);
      run_refresh(v, r, 34, -1, 32'd0, -1, 32'd0, r2);
      check_done(r2, 1'b0, "after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
